// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADC frame-lane alignment logic.
package adc_align_pkg;

    // Width of one deserialized lane word (1:8 DDR).
    localparam int unsigned LANE_WIDTH = 8;

    // Frame word produced by the ADC frame lane once the deserializer is aligned.
    localparam logic [LANE_WIDTH-1:0] FRAME_PATTERN = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCompare,
        StSlip,
        StLocked,
        StFail
    } align_state_t;

endpackage

// File: rtl/frame_align_ctrl.sv
// Bitslip sequencer for an ADC frame lane. Rotates the deserializer with one-cycle
// bitslip pulses until the frame word matches PATTERN for MATCH_COUNT consecutive
// words, then watches for sustained loss of alignment and realigns on its own.
module frame_align_ctrl
    import adc_align_pkg::*;
#(
    parameter logic [LANE_WIDTH-1:0] PATTERN       = FRAME_PATTERN,
    parameter int unsigned           SETTLE_CYCLES = 4,
    parameter int unsigned           MATCH_COUNT   = 16,
    parameter int unsigned           MAX_SLIPS     = 8,
    parameter int unsigned           LOSS_LIMIT    = 4
) (
    input  logic                  CLKDIV,
    input  logic                  RST,
    input  logic                  start,
    input  logic [LANE_WIDTH-1:0] frame_i,
    output logic                  bitslip_o,
    output logic                  aligned_o,
    output logic                  fail_o,
    output logic                  busy_o,
    output logic [3:0]            slip_count_o,
    output logic [15:0]           err_count_o
);

    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned LossW   = $clog2(LOSS_LIMIT + 1);

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [MatchW-1:0]  MatchLast  = MatchW'(MATCH_COUNT - 1);
    localparam logic [LossW-1:0]   LossLast   = LossW'(LOSS_LIMIT - 1);
    localparam logic [3:0]         SlipMax    = 4'(MAX_SLIPS);

    align_state_t       state_q;
    logic [SettleW-1:0] settle_cnt_q;
    logic [MatchW-1:0]  match_cnt_q;
    logic [LossW-1:0]   loss_cnt_q;
    logic [3:0]         slip_count_q;
    logic [15:0]        err_count_q;
    logic               bitslip_q;
    logic               aligned_q;
    logic               fail_q;
    logic               busy_q;
    logic               frame_match;

    // Full-width comparison; every bit of the frame word must match.
    assign frame_match = (frame_i == PATTERN);

    // Alignment FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLKDIV) begin
        // Bitslip is a single-cycle strobe; only the COMPARE->SLIP edge raises it.
        bitslip_q <= 1'b0;
        if (RST) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            slip_count_q <= '0;
            err_count_q  <= '0;
            aligned_q    <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (start) begin
            state_q      <= StSettle;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            slip_count_q <= '0;
            err_count_q  <= '0;
            aligned_q    <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                // Let the deserializer output settle after a slip before judging it.
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q      <= StCompare;
                        settle_cnt_q <= '0;
                        match_cnt_q  <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SettleW'(1);
                    end
                end
                StCompare: begin
                    if (frame_match) begin
                        match_cnt_q <= match_cnt_q + MatchW'(1);
                        if (match_cnt_q == MatchLast) begin
                            state_q   <= StLocked;
                            aligned_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end else if (slip_count_q >= SlipMax) begin
                        // Every rotation has been tried without a match.
                        state_q <= StFail;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= StSlip;
                        bitslip_q    <= 1'b1;
                        slip_count_q <= slip_count_q + 4'd1;
                    end
                end
                StSlip: begin
                    state_q      <= StSettle;
                    settle_cnt_q <= '0;
                    match_cnt_q  <= '0;
                end
                StLocked: begin
                    if (frame_match) begin
                        loss_cnt_q <= '0;
                    end else begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_q <= err_count_q + 16'd1;
                        end
                        if (loss_cnt_q == LossLast) begin
                            // Sustained loss: realign from scratch, keep the error history.
                            state_q      <= StSettle;
                            aligned_q    <= 1'b0;
                            busy_q       <= 1'b1;
                            slip_count_q <= '0;
                            match_cnt_q  <= '0;
                            loss_cnt_q   <= '0;
                            settle_cnt_q <= '0;
                        end else begin
                            loss_cnt_q <= loss_cnt_q + LossW'(1);
                        end
                    end
                end
                StFail: begin
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bitslip_o    = bitslip_q;
    assign aligned_o    = aligned_q;
    assign fail_o       = fail_q;
    assign busy_o       = busy_q;
    assign slip_count_o = slip_count_q;
    assign err_count_o  = err_count_q;

endmodule
